// File: rtl/cpu_pkg.sv
// Shared core definitions: fetch FSM states, reset PC, ALU op codes.
// Imported by the PC/fetch sequencer and its next-PC calculator.
package cpu_pkg;

    typedef enum logic [1:0] {
        RESET_ST = 2'd0,
        FETCH    = 2'd1,
        ISSUE    = 2'd2,
        EXEC     = 2'd3
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] WORD_BYTES   = 32'd4;

    localparam logic [2:0] ALU_AND  = 3'b100;
    localparam logic [2:0] ALU_OR   = 3'b101;
    localparam logic [2:0] ALU_BEQ  = 3'b110;
    localparam logic [2:0] ALU_BNEQ = 3'b111;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection: jump, taken branch, or sequential.
// All arithmetic wraps modulo 2^32.
module pc_next_calc
    import cpu_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic        branch_i,
    input  logic        jump_i,
    input  logic        zero_i,
    input  logic [15:0] imm16_i,
    input  logic [25:0] jtarget_i,
    output logic [31:0] pc_plus4_o,
    output logic [31:0] next_pc_o
);

    logic [31:0] br_off;

    assign pc_plus4_o = pc_i + WORD_BYTES;
    assign br_off     = {{14{imm16_i[15]}}, imm16_i, 2'b00};

    always_comb begin
        next_pc_o = pc_plus4_o;
        if (jump_i) begin
            next_pc_o = {pc_plus4_o[31:28], jtarget_i, 2'b00};
        end else if (branch_i && zero_i) begin
            next_pc_o = pc_plus4_o + br_off;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and fetch/issue/exec sequencer for the single-cycle core.
// Optional branch statistics counters under PC_BRANCH_STATS_EN.
module pc_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    output logic        instr_valid,
    input  logic        exec_done,
    input  logic        branch,
    input  logic        jump,
    input  logic        zero,
    input  logic [15:0] imm16,
    input  logic [25:0] jtarget,
`ifdef PC_BRANCH_STATS_EN
    output logic [15:0] br_taken_cnt,
    output logic [15:0] br_not_taken_cnt,
`endif
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  next_pc;
    logic         retire;

    pc_next_calc u_next (
        .pc_i       (pc_q),
        .branch_i   (branch),
        .jump_i     (jump),
        .zero_i     (zero),
        .imm16_i    (imm16),
        .jtarget_i  (jtarget),
        .pc_plus4_o (pc_plus4),
        .next_pc_o  (next_pc)
    );

    assign retire = (state_q == EXEC) && exec_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RESET_ST;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            RESET_ST: state_d = FETCH;
            FETCH:    if (imem_ack) state_d = ISSUE;
            ISSUE:    state_d = EXEC;
            EXEC: begin
                if (exec_done) begin
                    state_d = FETCH;
                    pc_d    = next_pc;
                end
            end
            default:  state_d = RESET_ST;
        endcase
    end

    assign imem_req    = (state_q == FETCH);
    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == ISSUE);
    assign pc          = pc_q;

`ifdef PC_BRANCH_STATS_EN
    logic [15:0] tk_q, ntk_q;
    logic        br_cnt;

    assign br_cnt = retire && branch && !jump;

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tk_q  <= '0;
            ntk_q <= '0;
        end else if (br_cnt) begin
            if (zero && tk_q != 16'hFFFF) tk_q <= tk_q + 16'd1;
            if (!zero && ntk_q != 16'hFFFF) ntk_q <= ntk_q + 16'd1;
        end
    end

    assign br_taken_cnt     = tk_q;
    assign br_not_taken_cnt = ntk_q;
`else
    logic unused_retire;
    assign unused_retire = retire;
`endif

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program-counter and fetch sequencer for the single-cycle core, directly downstream of the logic unit. Consumes its `zero` flag, along with the decoder's branch/jump controls, to select the next PC. Drives the instruction-memory request handshake and paces the datapath one instruction at a time.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.

Ports (all widths in bits):
- `clk`  in  1  single system clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  32  fetch address; equals `pc` while `imem_req`=1.
- `imem_ack`  in  1  memory has returned the instruction this cycle.
- `instr_valid`  out  1  one-cycle pulse; the fetched instruction is presented to the datapath.
- `exec_done`  in  1  datapath has finished the current instruction; control inputs below are valid.
- `branch`  in  1  current instruction is beq/bneq.
- `jump`  in  1  current instruction is j.
- `zero`  in  1  logic-unit flag; 1 = branch condition met (covers both beq and bneq encodings).
- `imm16`  in  16  branch offset, in words.
- `jtarget`  in  26  jump target field.
- `pc`  out  32  current PC.
- `pc_plus4`  out  32  `pc`+4, for link/debug.

## Operation
- States: RESET_ST, FETCH, ISSUE, EXEC.
- RESET_ST: entered asynchronously on `rst_n`=0; `pc`=RESET_PC. Goes to FETCH on the first edge after release.
- FETCH: `imem_req`=1. On `imem_ack`=1, go to ISSUE; otherwise hold.
- ISSUE: `instr_valid`=1 for exactly one cycle, then go to EXEC.
- EXEC: wait for `exec_done`. On `exec_done`=1, load `pc`=next_pc and go to FETCH.
- next_pc priority:
  - `jump`: {pc_plus4[31:28], jtarget, 2'b00}.
  - else `branch` & `zero`: pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00}.
  - else: pc_plus4.
- Arithmetic is modulo 2^32. 32'hFFFF_FFFC + 4 wraps to 0. Negative offsets wrap likewise. No exception is raised.
- `imem_ack` is ignored outside FETCH. `exec_done` and the control inputs are ignored outside EXEC.
- `branch`=1 and `jump`=1 together: jump wins.

## Timing
- Reset values:
  - `pc`=RESET_PC, `pc_plus4`=RESET_PC+4.
  - `imem_req`=0, `instr_valid`=0, state=RESET_ST.
  - Stats counters (if present) = 0.
- `imem_req` rises one cycle after `rst_n` deasserts.
- Ack on the first request cycle gives minimum fetch-to-issue latency of 1 cycle. Each extra cycle without ack adds one cycle.
- `exec_done` sampled at edge N: new `pc` is visible after edge N, and `imem_req`=1 in cycle N+1.
- Minimum instruction period: 3 cycles (FETCH, ISSUE, EXEC with immediate ack and done).
- Reset asserted mid-FETCH or mid-EXEC: all outputs return to reset values immediately. The pending fetch is dropped, and a late `imem_ack` is ignored.
- `imem_addr` is stable for the whole request until ack.

## Configuration
- `PC_BRANCH_STATS_EN` defined:
  - Adds outputs `br_taken_cnt` and `br_not_taken_cnt` (16 bits each).
  - Counters update on `exec_done` in EXEC with `branch`=1 and `jump`=0.
  - Counters saturate at 16'hFFFF.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

## Structure
- Shared package `cpu_pkg` holds:
  - state enum.
  - `RESET_PC` default.
  - AluOp encodings (3'b100 and, 3'b101 or, 3'b110 beq, 3'b111 bneq).
  - `WORD_BYTES`=4.
- One combinational sub-module `pc_next_calc` (inputs pc, branch, jump, zero, imm16, jtarget; output next_pc). FSM and registers stay in the top module.

## Test plan
- Reset release, `imem_ack` tied 1, `exec_done` each EXEC, no branch: `imem_addr` sequence 0x0, 0x4, 0x8, one instruction per 3 cycles.
- At pc=0x10, `branch`=1, `zero`=1, `imm16`=16'hFFFC: next fetch 0x04. Same with `zero`=0: next fetch 0x14.
- At pc=0x1000_0000, `jump`=1 and `branch`=1, `zero`=1, `jtarget`=26'h40: next fetch 0x1000_0100.
- `imem_ack` delayed 5 cycles: `imem_req` and `imem_addr` held stable, then one `instr_valid` pulse. A stray `imem_ack` in EXEC has no effect.
- pc=0xFFFF_FFFC, no branch: next fetch 0x0000_0000.
- Reset pulsed mid-EXEC: `pc`=0 and `instr_valid`=0 at once. With `PC_BRANCH_STATS_EN`, 3 taken and 2 not-taken branches give counts 3 and 2, and both clear on reset.
